snes_pad_reader: RTL and testbench
==================================

# snes_pad_reader

Serial gamepad front end for the Dino Run game on DE1-SoC. It polls an SNES-style controller over the latch/clock/data wires and decodes the 16-bit serial frame. It then presents an 8-bit active-high button report to the game logic, together with a frame-valid strobe and a Start-press edge pulse used for replay after game over. It sits between the GPIO pins and the `controller_report` input of the display/game block.

## Interface
Parameters:
- `LATCH_CYCLES`, default 600: `pad_latch` high time in clk cycles (12 µs at 50 MHz); must be ≥ 4.
- `HALF_CYCLES`, default 300: each `pad_clk` half-period in clk cycles (6 µs); must be ≥ 4.
- `POLL_CYCLES`, default 833_333: frame start period (60 Hz); must exceed `LATCH_CYCLES + 30*HALF_CYCLES + 2`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: reset, asynchronous, active-high.
- `pad_data` in 1: serial data from pad, active-low (0 = pressed), asynchronous to `clk`.
- `pad_latch` out 1: latch pulse to pad, active-high.
- `pad_clk` out 1: shift clock to pad, idles high.
- `report` out 8: decoded buttons, 1 = pressed. [0]=B, [1]=A, [2]=Up, [3]=Down, [4]=Start, [5]=Select, [6]=L, [7]=R.
- `report_valid` out 1: one-cycle pulse when `report` and `pad_ok` update.
- `start_pressed` out 1: one-cycle pulse on 0→1 transition of `report[4]`.
- `pad_ok` out 1: last frame's trailer bits were well-formed.

## Operation
- `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- A free-running poll counter counts 0..`POLL_CYCLES-1` and wraps. The wrap cycle is the poll tick.
- FSM states:
  - IDLE: wait for poll tick, then go to LATCH.
  - LATCH: `pad_latch`=1 for `LATCH_CYCLES` cycles. Sample raw bit 0 on the last LATCH cycle. Go to CLK_LO.
  - CLK_LO: `pad_clk`=0 for `HALF_CYCLES`. Go to CLK_HI.
  - CLK_HI: `pad_clk`=1 for `HALF_CYCLES`. Sample raw bit i on the last cycle. If i=15 go to DONE, else return to CLK_LO.
  - DONE: one cycle; commit results, then IDLE.
- Raw bit order (pad order): 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12–15 trailer.
- Decode: pressed = ~raw. Report mapping: B←0, A←8, Up←4, Down←5, Start←3, Select←2, L←10, R←11. Y, X, Left and Right are dropped.
- `pad_ok` = raw[15:12] == 4'b1111, i.e. trailer reads released.
  - Disconnected pad with pull-down: all raw 0, so `pad_ok`=0.
  - When `pad_ok`=0, `report` is forced to 8'h00 so that a missing pad never triggers Start.
- On commit, `start_pressed` = new `report[4]` & ~old `report[4]`.
- Poll ticks that occur while the FSM is not in IDLE are ignored; there is no queued frame.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=1, `report`=0, `report_valid`=0, `start_pressed`=0, `pad_ok`=0. Poll counter=0, FSM=IDLE, synchronizer flops=1.
- After reset, the first latch rises the cycle after the first poll tick, i.e. clk edge `POLL_CYCLES` after reset release.
- Frame length from latch rise to DONE is `LATCH_CYCLES + 30*HALF_CYCLES` cycles. `report`, `pad_ok`, `report_valid` and `start_pressed` all update on the clock edge leaving DONE and are coincident.
- `pad_data` to sample latency is 2 cycles, absorbed by the ≥ 4-cycle half-period.
- `pad_latch` and `pad_clk` are registered outputs with no glitches.
- Reset asserted mid-frame aborts immediately to reset values. No partial report is committed.

## Configuration
- `PAD_DEBOUNCE_EN`: when defined, a decoded frame is committed only if it equals the previous decoded frame (8 report bits plus `pad_ok`). Otherwise it is stored as the candidate and `report_valid` still pulses with `report` unchanged. Consequences:
  - A change appears after 2 consecutive identical frames.
  - `start_pressed` fires only on committed changes.
  - The candidate resets to 0 with `pad_ok` 0.
- When undefined, every frame commits directly.

## Test plan
Bench parameters: `LATCH_CYCLES`=4, `HALF_CYCLES`=4, `POLL_CYCLES`=200, so frame length = 124 cycles.
- Reset release, pad model all released with trailer high -> latch rises at cycle 200 and is high 4 cycles. 15 `pad_clk` low pulses of 4 cycles follow. `report_valid` pulses once, with `report`=8'h00 and `pad_ok`=1.
- Pad drives Start and A pressed (raw bits 3 and 8 low) -> `report`=8'h12 and `start_pressed` pulses with `report_valid`. The same pattern next frame gives `report`=8'h12 and no `start_pressed`.
- `pad_data` tied low (no pad) -> `pad_ok`=0, `report`=8'h00, no `start_pressed`.
- Assert reset at latch-rise+50 -> `pad_clk`=1 and `pad_latch`=0 immediately, and no `report_valid` until a full new frame completes 200 cycles after release.
- With `PAD_DEBOUNCE_EN`, B pressed for exactly one frame -> `report` stays 8'h00. B held two frames -> `report`=8'h01 after the second `report_valid`.
- Toggle `pad_data` asynchronously mid-half-period -> the sampled value equals the level held over the last 3 cycles of the CLK_HI half.

Source files
------------

// File: rtl/snes_pad_reader.sv
// SNES controller poller: latches the pad, shifts out 16 bits, decodes an 8-bit button report.
// Optional PAD_DEBOUNCE_EN: commit a frame only when it matches the previous decoded frame.
module snes_pad_reader #(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833_333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] report,
  output logic       report_valid,
  output logic       start_pressed,
  output logic       pad_ok
);

  localparam int PCW = $clog2(POLL_CYCLES);
  localparam int PHW = $clog2((LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_r, next_state_s;
  logic             sync1_r, sync2_r;
  logic [PCW-1:0]   poll_cnt_r;
  logic             poll_tick_s;
  logic [PHW-1:0]   phase_cnt_r;
  logic             phase_end_s;
  logic [3:0]       bit_idx_r;
  logic [15:0]      raw_r;
  logic [8:0]       decoded_s;
  logic             commit_s;
  logic             latch_next_s, clk_next_s, valid_next_s, start_next_s, ok_next_s;
  logic [7:0]       report_next_s;

  // Result is {pad_ok, report}; a bad trailer blanks every button so no phantom Start.
  function automatic logic [8:0] decode_frame(input logic [15:0] raw);
    logic [15:0] p;
    logic        ok;
    p  = ~raw;
    ok = (raw[15:12] == 4'b1111);
    return {ok, (ok ? {p[11], p[10], p[2], p[3], p[5], p[4], p[8], p[0]} : 8'h00)};
  endfunction

  // Synchronizer and free-running poll counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      poll_cnt_r <= '0;
    end else begin
      sync1_r    <= pad_data;
      sync2_r    <= sync1_r;
      poll_cnt_r <= poll_tick_s ? '0 : poll_cnt_r + 1'b1;
    end
  end

  assign poll_tick_s = (poll_cnt_r == PCW'(POLL_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    phase_end_s  = 1'b0;
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (poll_tick_s) next_state_s = LATCH;
        else             next_state_s = IDLE;
      end
      LATCH: begin
        phase_end_s = (phase_cnt_r == PHW'(LATCH_CYCLES - 1));
        if (phase_end_s) next_state_s = CLK_LO;
        else             next_state_s = LATCH;
      end
      CLK_LO: begin
        phase_end_s = (phase_cnt_r == PHW'(HALF_CYCLES - 1));
        if (phase_end_s) next_state_s = CLK_HI;
        else             next_state_s = CLK_LO;
      end
      CLK_HI: begin
        phase_end_s = (phase_cnt_r == PHW'(HALF_CYCLES - 1));
        if (phase_end_s) next_state_s = (bit_idx_r == 4'd15) ? DONE : CLK_LO;
        else             next_state_s = CLK_HI;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Phase timer and serial capture; bit 0 arrives during latch, the rest on pad_clk highs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt_r <= '0;
      bit_idx_r   <= 4'd0;
      raw_r       <= 16'h0000;
    end else begin
      if (state_r == IDLE || next_state_s != state_r) phase_cnt_r <= '0;
      else                                             phase_cnt_r <= phase_cnt_r + 1'b1;
      if (state_r == LATCH && phase_end_s) begin
        raw_r[0]  <= sync2_r;
        bit_idx_r <= 4'd1;
      end else if (state_r == CLK_HI && phase_end_s) begin
        raw_r[bit_idx_r] <= sync2_r;
        bit_idx_r        <= bit_idx_r + 4'd1;
      end else begin
        bit_idx_r <= bit_idx_r;
      end
    end
  end

  assign decoded_s = decode_frame(raw_r);

`ifdef PAD_DEBOUNCE_EN
  logic [8:0] cand_r;

  // Candidate frame: last decoded frame, compared against the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cand_r <= 9'h000;
    else if (state_r == DONE)  cand_r <= decoded_s;
    else                       cand_r <= cand_r;
  end

  assign commit_s = (state_r == DONE) && (decoded_s == cand_r);
`else
  assign commit_s = (state_r == DONE);
`endif

  // Output logic: next values of every registered output.
  always_comb begin
    latch_next_s = (next_state_s == LATCH);
    clk_next_s   = (next_state_s != CLK_LO);
    valid_next_s = (state_r == DONE);
    if (commit_s) begin
      report_next_s = decoded_s[7:0];
      ok_next_s     = decoded_s[8];
      start_next_s  = decoded_s[4] & ~report[4];
    end else begin
      report_next_s = report;
      ok_next_s     = pad_ok;
      start_next_s  = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_latch     <= 1'b0;
      pad_clk       <= 1'b1;
      report        <= 8'h00;
      report_valid  <= 1'b0;
      start_pressed <= 1'b0;
      pad_ok        <= 1'b0;
    end else begin
      pad_latch     <= latch_next_s;
      pad_clk       <= clk_next_s;
      report        <= report_next_s;
      report_valid  <= valid_next_s;
      start_pressed <= start_next_s;
      pad_ok        <= ok_next_s;
    end
  end

endmodule

// File: tb/tb_snes_pad_reader.sv
// Scoreboard bench for snes_pad_reader: behavioural pad model, reference model queue, monitor.
module tb_snes_pad_reader;

  localparam int L = 4;
  localparam int H = 4;
  localparam int P = 200;
  // Report bit i comes from this pad-order raw bit.
  localparam int MAP [8] = '{0, 8, 4, 5, 3, 2, 10, 11};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data = 1'b1;
  logic       pad_latch, pad_clk;
  logic [7:0] report;
  logic       report_valid, start_pressed, pad_ok;

  typedef struct {
    logic [7:0] rep;
    logic       ok;
    logic       start;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [15:0] pad_frame = 16'hFFFF;
  bit          glitch_en = 1'b0;
  logic [7:0]  m_rep = 8'h00;
  logic        m_ok = 1'b0;
  logic [8:0]  m_cand = 9'h000;

  snes_pad_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .report(report), .report_valid(report_valid),
    .start_pressed(start_pressed), .pad_ok(pad_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Pad model: latch loads the shift register, each pad_clk rise advances one bit.
  int idx = 16;
  logic clk_prev = 1'b1;
  always @(posedge clk) begin
    bit rose;
    #2;
    rose = pad_clk && !clk_prev;
    clk_prev = pad_clk;
    if (pad_latch) idx = 0;
    else if (rose) idx = idx + 1;
    pad_data = (idx < 16) ? pad_frame[idx] : 1'b1;
    if (glitch_en && rose && idx < 16) begin
      pad_data = ~pad_frame[idx];
      #3;
      pad_data = pad_frame[idx];
    end
  end

  // Reference model: what the game should see after this pad frame.
  task automatic model_push(input logic [15:0] f);
    exp_t       e;
    logic       ok;
    logic [7:0] rep;
    bit         commit;
    ok  = (f[15:12] == 4'hF);
    rep = 8'h00;
    for (int i = 0; i < 8; i++) rep[i] = ok && !f[MAP[i]];
`ifdef PAD_DEBOUNCE_EN
    commit = ({ok, rep} == m_cand);
    m_cand = {ok, rep};
`else
    commit = 1'b1;
`endif
    e.start = commit && rep[4] && !m_rep[4];
    if (commit) begin
      m_rep = rep;
      m_ok  = ok;
    end
    e.rep = m_rep;
    e.ok  = m_ok;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_rep  = 8'h00;
    m_ok   = 1'b0;
    m_cand = 9'h000;
    q.delete();
  endtask

  // Monitor: every report_valid consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (report_valid) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: report %0h with empty scoreboard", report);
        end else begin
          e = q.pop_front();
          check("report", report, e.rep);
          check("pad_ok", pad_ok, e.ok);
          check("start_pressed", start_pressed, e.start);
        end
      end else if (start_pressed) begin
        total++;
        $display("FAIL stray_start: start_pressed=1 required 0 outside report_valid");
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (report_valid) break;
      n++;
    end
    if (n >= 400) fail_now("wait_valid");
  endtask

  task automatic run_frame(input logic [15:0] f, input bit glitch);
    pad_frame = f;
    glitch_en = glitch;
    model_push(f);
    wait_valid();
    glitch_en = 1'b0;
  endtask

  task automatic wait_latch_rise();
    int n = 0;
    @(negedge clk);
    while (!pad_latch && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!pad_latch) fail_now("wait_latch");
  endtask

  // First frame after a reset release: check latch, clock pulses and commit timing.
  task automatic first_frame_timing(input logic [15:0] f);
    int lat = 0, lows = 0, pulses = 0, n = 0;
    logic prev = 1'b1;
    pad_frame = f;
    model_push(f);
    wait_latch_rise();
    check("latch_rise_cycle", cyc, P);
    while (pad_latch && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check("latch_width", lat, L);
    while (!report_valid && n < 400) begin
      if (!pad_clk) lows++;
      if (prev && !pad_clk) pulses++;
      prev = pad_clk;
      n++;
      @(negedge clk);
    end
    if (!report_valid) fail_now("first_valid");
    check("clk_low_pulses", pulses, 15);
    check("clk_low_cycles", lows, 15 * H);
    check("valid_cycle", cyc, P + L + 30 * H + 1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [15:0] f;
    int r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_latch", pad_latch, 1'b0);
    check("rst_clk", pad_clk, 1'b1);
    check("rst_report", report, 8'h00);
    check("rst_valid", report_valid, 1'b0);
    check("rst_start", start_pressed, 1'b0);
    check("rst_ok", pad_ok, 1'b0);
    release_reset();

    first_frame_timing(16'hFFFF);
    run_frame(16'hFEF7, 1'b0);
    run_frame(16'hFEF7, 1'b0);
    run_frame(16'h0000, 1'b0);
    run_frame(16'hFFFE, 1'b0);
    run_frame(16'hFFFF, 1'b0);
    run_frame(16'hFFFE, 1'b0);
    run_frame(16'hFFFE, 1'b0);
    run_frame(16'hF5A6, 1'b1);
    run_frame(16'hF5A6, 1'b1);
    run_frame(16'hFAF5, 1'b1);

    for (int k = 0; k < 14; k++) begin
      f = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 8)       f[15:12] = 4'hF;
      else if (r == 8) f = 16'h0000;
      if (r == 3) run_frame(f, 1'b0);
      run_frame(f, k[0]);
    end

    // Reset 50 cycles into a frame: outputs return at once, nothing partial commits.
    pad_frame = 16'hFEF7;
    wait_latch_rise();
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_clk", pad_clk, 1'b1);
    check("mid_rst_latch", pad_latch, 1'b0);
    check("mid_rst_report", report, 8'h00);
    check("mid_rst_ok", pad_ok, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    release_reset();
    first_frame_timing(16'hFEF7);
    run_frame(16'hFEF7, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
